// File: rtl/jb_pkg.sv
// Joybus shared definitions: transmitter FSM states and the bit-timing constants
// (in microseconds) that both the transmitter and the receiver are built around.
package jb_pkg;

  typedef enum logic [2:0] {
    IDLE,
    BIT_LOW,
    BIT_HIGH,
    STOP_LOW,
    GUARD
  } jb_tx_state_t;

  localparam int JB_BIT_US       = 4;
  localparam int JB_ONE_LOW_US   = 1;
  localparam int JB_ZERO_LOW_US  = 3;
  localparam int JB_STOP_CONS_US = 1;
  localparam int JB_STOP_CTLR_US = 2;

  // Low time of a data cell; the high time is the rest of JB_BIT_US.
  function automatic int jb_low_us(input logic bit_val);
    return bit_val ? JB_ONE_LOW_US : JB_ZERO_LOW_US;
  endfunction

endpackage

// File: rtl/jb_us_timer.sv
// Microsecond phase timer: a CLKS_PER_US prescaler plus a loadable down-counter of
// whole microseconds. A phase ends on the clk where tick_o and expire_o are both high.
module jb_us_timer #(
  parameter int CLKS_PER_US = 25,
  parameter int US_W        = 3
) (
  input  logic            clk,
  input  logic            rst,
  input  logic            load_i,
  input  logic [US_W-1:0] load_us_i,
  output logic            tick_o,
  output logic            expire_o
);

  localparam int PW = (CLKS_PER_US > 1) ? $clog2(CLKS_PER_US) : 1;

  logic [PW-1:0]   presc_q, presc_d;
  logic [US_W-1:0] us_q, us_d;

  assign tick_o   = (presc_q == PW'(CLKS_PER_US - 1));
  assign expire_o = (us_q == US_W'(1));

  // NOTE: every always_comb output gets a default first, so no path can infer a latch.
  always_comb begin
    presc_d = tick_o ? '0 : presc_q + 1'b1;
    us_d    = us_q;
    if (tick_o && us_q != '0) us_d = us_q - 1'b1;
    // A load restarts the prescaler so the new phase gets full microseconds.
    if (load_i) begin
      presc_d = '0;
      us_d    = load_us_i;
    end
  end

  // NOTE: state registers use non-blocking assignments so all flops update together.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      presc_q <= '0;
      us_q    <= '0;
    end else begin
      presc_q <= presc_d;
      us_q    <= us_d;
    end
  end

endmodule

// File: rtl/jb_tx.sv
// Joybus open-drain serializer: sends 1..MAX_BYTES bytes MSB-first, a stop bit, then
// holds the line released for a guard time. Drives only the pull-low enable jb_oe.
module jb_tx
  import jb_pkg::*;
#(
  parameter int CLKS_PER_US = 25,
  parameter int MAX_BYTES   = 8,
  parameter int GUARD_US    = 2
) (
  input  logic                             clk,
  input  logic                             rst,
  input  logic                             start,
  input  logic [$clog2(MAX_BYTES+1)-1:0]   num_bytes,
  input  logic [MAX_BYTES*8-1:0]           data,
  input  logic                             stop_long,
  output logic                             busy,
  output logic                             done,
  output logic                             jb_oe
);

  localparam int NB_W = $clog2(MAX_BYTES + 1);
  localparam int DW   = MAX_BYTES * 8;
  localparam int BC_W = $clog2(DW + 1);
  localparam int US_W = $clog2(GUARD_US + JB_BIT_US + 1);

  jb_tx_state_t    state_q, state_d;
  logic [DW-1:0]   shift_q, shift_d;
  logic [BC_W-1:0] bits_q, bits_d;
  logic            stop_long_q, stop_long_d;
  logic            busy_q, busy_d;
  logic            done_q, done_d;
  logic            oe_q, oe_d;

  logic            load;
  logic [US_W-1:0] load_us;
  logic            tick, expire, phase_end;
  logic [NB_W-1:0] nb_eff;

  jb_us_timer #(
    .CLKS_PER_US (CLKS_PER_US),
    .US_W        (US_W)
  ) u_timer (
    .clk       (clk),
    .rst       (rst),
    .load_i    (load),
    .load_us_i (load_us),
    .tick_o    (tick),
    .expire_o  (expire)
  );

  assign phase_end = tick && expire;
  assign nb_eff    = (num_bytes > NB_W'(MAX_BYTES)) ? NB_W'(MAX_BYTES) : num_bytes;

  always_comb begin
    state_d     = state_q;
    shift_d     = shift_q;
    bits_d      = bits_q;
    stop_long_d = stop_long_q;
    done_d      = 1'b0;
    load        = 1'b0;
    load_us     = '0;
    unique case (state_q)
      IDLE: begin
        if (start) begin
          if (nb_eff == '0) begin
            done_d = 1'b1;
          end else begin
            shift_d     = data;
            bits_d      = BC_W'({nb_eff, 3'b000});
            stop_long_d = stop_long;
            load        = 1'b1;
            load_us     = US_W'(jb_low_us(data[DW-1]));
            state_d     = BIT_LOW;
          end
        end
      end
      BIT_LOW: begin
        if (phase_end) begin
          load    = 1'b1;
          load_us = US_W'(JB_BIT_US - jb_low_us(shift_q[DW-1]));
          state_d = BIT_HIGH;
        end
      end
      BIT_HIGH: begin
        // Cell end: the next cell (or the stop bit) starts on the very next clk.
        if (phase_end) begin
          shift_d = shift_q << 1;
          bits_d  = bits_q - 1'b1;
          load    = 1'b1;
          if (bits_q == BC_W'(1)) begin
            load_us = US_W'(stop_long_q ? JB_STOP_CTLR_US : JB_STOP_CONS_US);
            state_d = STOP_LOW;
          end else begin
            load_us = US_W'(jb_low_us(shift_q[DW-2]));
            state_d = BIT_LOW;
          end
        end
      end
      STOP_LOW: begin
        if (phase_end) begin
          load    = 1'b1;
          load_us = US_W'(GUARD_US);
          state_d = GUARD;
        end
      end
      GUARD: begin
        if (phase_end) begin
          done_d  = 1'b1;
          state_d = IDLE;
        end
      end
      default: state_d = IDLE;
    endcase
    // Outputs are decoded from the next state so the registered pad enable lines up with it.
    oe_d   = (state_d == BIT_LOW) || (state_d == STOP_LOW);
    busy_d = (state_d != IDLE);
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q     <= IDLE;
      shift_q     <= '0;
      bits_q      <= '0;
      stop_long_q <= 1'b0;
      busy_q      <= 1'b0;
      done_q      <= 1'b0;
      oe_q        <= 1'b0;
    end else begin
      state_q     <= state_d;
      shift_q     <= shift_d;
      bits_q      <= bits_d;
      stop_long_q <= stop_long_d;
      busy_q      <= busy_d;
      done_q      <= done_d;
      oe_q        <= oe_d;
    end
  end

  assign busy  = busy_q;
  assign done  = done_q;
  assign jb_oe = oe_q;

endmodule

// File: tb/tb_jb_tx.sv
// Directed bench for jb_tx: builds the expected line waveform from the bit timing,
// compares it clk by clk, and independently decodes the captured line back to bytes.
module tb_jb_tx;

  localparam int C = 25;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic        start = 1'b0;
  logic [3:0]  num_bytes = '0;
  logic [63:0] data = '0;
  logic        stop_long = 1'b0;
  logic        busy, done, jb_oe;

  int checks = 0;
  int errors = 0;

  jb_tx #(.CLKS_PER_US(C), .MAX_BYTES(8), .GUARD_US(2)) dut (
    .clk       (clk),
    .rst       (rst),
    .start     (start),
    .num_bytes (num_bytes),
    .data      (data),
    .stop_long (stop_long),
    .busy      (busy),
    .done      (done),
    .jb_oe     (jb_oe)
  );

  always #20 clk = ~clk;

  task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  // Cycle 0 is the clk in which start is high; the frame occupies cycles 1..total.
  task automatic run_frame(input string tag, input int nb, input logic [63:0] d,
                           input logic sl, input int restart_at, input int exp_done_cyc);
    bit   wave[$];
    bit   got[$];
    int   runs[$];
    int   nbe, total, run, oe_err, busy_err, done_cnt, done_cyc, first_high, idx;
    logic [63:0] dec, mask;
    nbe = (nb > 8) ? 8 : nb;
    for (int b = 0; b < nbe * 8; b++) begin
      int low;
      low = d[63 - b] ? C : 3 * C;
      for (int k = 0; k < 4 * C; k++) wave.push_back(k < low);
    end
    if (nbe > 0) begin
      for (int k = 0; k < (sl ? 2 * C : C); k++) wave.push_back(1'b1);
      for (int k = 0; k < 2 * C; k++) wave.push_back(1'b0);
    end
    total = wave.size();
    oe_err = 0; busy_err = 0; done_cnt = 0; done_cyc = 0;

    @(negedge clk);
    start = 1'b1; num_bytes = nb[3:0]; data = d; stop_long = sl;
    for (int cyc = 1; cyc <= total + 20; cyc++) begin
      @(negedge clk);
      start = (cyc == restart_at);
      if (cyc == 2) begin
        data = ~d; stop_long = ~sl; num_bytes = 4'd5;
      end
      got.push_back(jb_oe);
      if (jb_oe !== ((cyc <= total) ? wave[cyc-1] : 1'b0)) oe_err++;
      if (busy !== (cyc <= total)) busy_err++;
      if (done === 1'b1) begin
        done_cnt++;
        if (done_cyc == 0) done_cyc = cyc;
      end
    end
    start = 1'b0;

    check({tag, "/oe_wave_errs"}, oe_err, 0);
    check({tag, "/busy_errs"}, busy_err, 0);
    check({tag, "/done_cycle"}, done_cyc, exp_done_cyc);
    check({tag, "/done_pulses"}, done_cnt, 1);

    run = 0;
    foreach (got[i]) begin
      if (got[i]) run++;
      else if (run > 0) begin
        runs.push_back(run);
        run = 0;
      end
    end
    if (run > 0) runs.push_back(run);
    check({tag, "/low_runs"}, runs.size(), (nbe > 0) ? nbe * 8 + 1 : 0);
    if (nbe > 0 && runs.size() == nbe * 8 + 1) begin
      dec = '0;
      for (int b = 0; b < nbe * 8; b++) dec[63 - b] = (runs[b] < 2 * C);
      mask = {64{1'b1}} << (64 - nbe * 8);
      check({tag, "/decoded"}, dec, d & mask);
      check({tag, "/stop_len"}, runs[nbe * 8], sl ? 2 * C : C);
      first_high = 0;
      idx = runs[0];
      while (idx < got.size() && !got[idx]) begin
        first_high++;
        idx++;
      end
      check({tag, "/first_low"}, runs[0], d[63] ? C : 3 * C);
      check({tag, "/first_high"}, first_high, d[63] ? 3 * C : C);
    end
    repeat (3) @(negedge clk);
  endtask

  initial begin
    int act;
    #5;
    check("reset/oe", jb_oe, 0);
    check("reset/busy", busy, 0);
    check("reset/done", done, 0);
    repeat (2) @(negedge clk);
    rst = 1'b0;
    repeat (2) @(negedge clk);

    // Zero-length request: done next cycle, no line activity, busy stays low.
    run_frame("nb0", 0, 64'h0, 1'b0, 0, 1);
    // 0x40 0x03 0x01 console-stop frame.
    run_frame("cmd3", 3, 64'h4003_0100_0000_0000, 1'b0, 0, 2476);
    // Single 0xFF with controller stop.
    run_frame("ff_long", 1, 64'hFF00_0000_0000_0000, 1'b1, 0, 901);
    // Second start 10 clks in is ignored.
    run_frame("dbl_start", 1, 64'hA500_0000_0000_0000, 1'b0, 10, 901 - C);
    // Full-size alternating payload, cells back to back.
    run_frame("max", 8, 64'hAA55_AA55_AA55_AA55, 1'b0, 0, 6476);
    // Oversized byte count clamps to eight bytes.
    run_frame("clamp", 15, 64'h55AA_55AA_55AA_55AA, 1'b1, 0, 6501);

    // Reset during the first (3 us) low phase releases the line at once.
    @(negedge clk);
    start = 1'b1; num_bytes = 4'd1; data = 64'h0; stop_long = 1'b0;
    @(negedge clk);
    start = 1'b0;
    repeat (29) @(negedge clk);
    check("midrst/oe_before", jb_oe, 1);
    rst = 1'b1;
    #1;
    check("midrst/oe_now", jb_oe, 0);
    check("midrst/busy_now", busy, 0);
    @(negedge clk);
    rst = 1'b0;
    act = 0;
    repeat (300) begin
      @(negedge clk);
      if (jb_oe !== 1'b0 || busy !== 1'b0 || done !== 1'b0) act++;
    end
    check("midrst/quiet", act, 0);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
